dragon_move_sequencer: RTL and testbench
========================================

// Module: dragon_move_sequencer
// PURPOSE
//  Sequences the dragon: derives move slots from vsync frame edges and selects the head's target (player, or flee corner after a hit).
//  Issues one req/ack move handshake per slot to the dragon head, then a one-cycle body-shift pulse to the segment chain.
//  Tracks body length growth. Sits between the game top level, the dragon head and the body segment chain.
// PARAMETERS
//  BASE_PERIOD  10     frames between moves at speed_sel=0 (6-bit)
//  SPEED_STEP   2      frames removed per speed_sel increment
//  FLEE_FRAMES  60     frames spent fleeing after a hit (6-bit)
//  FLEE_POS     8'h00  flee target {x[3:0],y[3:0]}
//  INIT_LEN     2      body length after reset
//  MAX_LEN      8      body length ceiling (<=15)
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-low
//  vsync        in   1  frame sync; rising edge = new frame
//  player_pos   in   8  {x,y} player tile
//  speed_sel    in   2  speed level 0..3
//  hit          in   1  one-cycle pulse: player struck dragon
//  grow         in   1  one-cycle pulse: request one more segment
//  move_ack     in   1  head accepted the move; moved = head changed tile
//  moved        in   1  valid with move_ack
//  move_req     out  1  move request to head
//  target_pos   out  8  target for head, stable while move_req=1
//  body_shift   out  1  one-cycle pulse: segments shift one place
//  body_len     out  4  active segment count
//  fleeing      out  1  flee mode active
//  overrun      out  1  sticky: a slot was dropped while busy
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE, move_req=0, target_pos=0, body_shift=0, fleeing=0, overrun=0,
//   body_len=INIT_LEN, frame_cnt=0, flee_cnt=0, grow_pend=0, vsync_q=0. Reset mid-handshake aborts immediately.
//  Frame edge: fe = vsync & ~vsync_q (vsync_q registered every cycle). All counters advance on fe only.
//  Period P = BASE_PERIOD - SPEED_STEP*speed_sel (10/8/6/4 at defaults), sampled at each fe.
//  frame_cnt: on fe, if frame_cnt >= P-1 then frame_cnt<=0 and slot=1 for that cycle, else frame_cnt+1.
//   Speed change to a smaller P with frame_cnt already >= P-1 fires a slot on the next fe.
//  Flee: hit loads flee_cnt=FLEE_FRAMES; on fe, flee_cnt decrements if nonzero. fleeing = (flee_cnt!=0).
//   hit coincident with the fe that reaches 0: reload wins, stays fleeing.
//  FSM IDLE -> REQ -> SHIFT -> IDLE:
//   IDLE: on slot, latch target_pos = fleeing ? FLEE_POS : player_pos (registered next cycle); move_req<=1; go REQ.
//   REQ: move_req held 1, target_pos frozen. On move_ack: move_req<=0; if moved go SHIFT, else go IDLE.
//    move_ack must be ignored in IDLE/SHIFT.
//   SHIFT: body_shift=1 for exactly this cycle. If grow_pend and body_len<MAX_LEN: body_len+1, grow_pend<=0.
//    Always returns to IDLE.
//  Earliest next move_req is one cycle after SHIFT/ack; min req->req spacing >= P frames.
//  Slot arriving while state!=IDLE is dropped, overrun<=1 (sticky until reset); frame_cnt still wraps.
//  grow: sets grow_pend (coalesces multiple pulses). At body_len==MAX_LEN, growth discarded, grow_pend cleared at SHIFT.
//  grow coincident with SHIFT: applied in that SHIFT if grow_pend was already set; else pending for the next SHIFT.
//  All arithmetic unsigned; frame_cnt/flee_cnt 6-bit, no wrap below 0.
// STRUCTURE
//  Shared package/header dragon_pkg: state encoding (IDLE=2'd0, REQ=2'd1, SHIFT=2'd2), pos width 8, FLEE_POS default, MAX_LEN.
//  Sub-module frame_tick_gen: vsync edge detect + programmable period counter, outputs fe and slot.
//  Flee counter, FSM and length tracker live in the top module.
// TESTING
//  Reset: hold reset=0 for 3 cycles, toggle vsync -> all outputs 0, body_len=2, no move_req.
//  Cadence: speed_sel=0, 25 vsync edges, head acks 2 cycles after req with moved=1
//   -> move_req at edges 10 and 20 only; 2 body_shift pulses.
//  Flee: hit, then slot -> target_pos=8'h00; after 60 fe fleeing=0; next slot target_pos=player_pos (e.g. 8'h5A).
//  Overrun: speed_sel=3, withhold move_ack for 5 frames -> overrun=1, move_req stays 1, target_pos unchanged;
//   ack moved=0 -> no body_shift, back to IDLE.
//  Growth: 8 grow pulses interleaved with moves -> body_len saturates at 8.
//   Two grows between shifts add only 1.
//  Reset mid-REQ: reset=0 while move_req=1 -> next cycle move_req=0, state IDLE, body_len=2.

Source files
------------

// File: rtl/dragon_pkg.sv
// Shared definitions for the dragon move sequencer.
// Provides the sequencer state encoding, the position width,
// the default flee target and the default body-length ceiling.
package dragon_pkg;

  localparam int unsigned POS_W = 8;

  localparam logic [POS_W-1:0] FLEE_POS_DEF = 8'h00;
  localparam int unsigned MAX_LEN_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SHIFT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/dragon_move_sequencer_frame_tick_gen.sv
// frame_tick_gen: detects vsync rising edges and divides them into move slots.
// Ports:
//   clk, reset (sync, active-low)
//   vsync_i     frame sync, rising edge starts a frame
//   speed_sel_i speed level; period = BASE_PERIOD - SPEED_STEP*speed_sel
//   fe_o        one-cycle frame-edge strobe
//   slot_o      one-cycle strobe on the frame edge that completes a period
module frame_tick_gen #(
  parameter int unsigned BASE_PERIOD = 10,
  parameter int unsigned SPEED_STEP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_i,
  input  logic [1:0] speed_sel_i,
  output logic       fe_o,
  output logic       slot_o
);

  localparam logic [5:0] BASE_C = 6'(BASE_PERIOD);
  localparam logic [5:0] STEP_C = 6'(SPEED_STEP);

  logic       vsync_q;
  logic [5:0] frame_cnt_q;
  logic [5:0] frame_cnt_d;
  logic [5:0] period_s;
  logic [5:0] last_s;

  // Edge detect and period counter; the period is re-evaluated at every edge,
  // so a count already past a newly shortened period fires on the next edge.
  always_comb begin
    period_s    = BASE_C - (STEP_C * {4'd0, speed_sel_i});
    last_s      = period_s - 6'd1;
    fe_o        = vsync_i & ~vsync_q;
    slot_o      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (fe_o) begin
      if (frame_cnt_q >= last_s) begin
        frame_cnt_d = 6'd0;
        slot_o      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end
  end

  // Edge-detect history and frame counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= 6'd0;
    end else begin
      vsync_q     <= vsync_i;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/dragon_move_sequencer.sv
// dragon_move_sequencer: paces dragon moves from vsync, picks the head target,
// runs the req/ack handshake with the head and pulses the body chain shift.
// Ports:
//   clk, reset (sync, active-low)
//   vsync_i, speed_sel_i        frame timing and speed level
//   player_pos_i                player tile {x,y}
//   hit_i, grow_i               one-cycle event pulses
//   move_ack_i, moved_i         head handshake response
//   move_req_o, target_pos_o    head handshake request and target
//   body_shift_o                one-cycle segment shift pulse
//   body_len_o                  active segment count
//   fleeing_o                   flee mode active
//   overrun_o                   sticky: a slot was dropped while busy
module dragon_move_sequencer
  import dragon_pkg::*;
#(
  parameter int unsigned      BASE_PERIOD = 10,
  parameter int unsigned      SPEED_STEP  = 2,
  parameter int unsigned      FLEE_FRAMES = 60,
  parameter logic [POS_W-1:0] FLEE_POS    = FLEE_POS_DEF,
  parameter int unsigned      INIT_LEN    = 2,
  parameter int unsigned      MAX_LEN     = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_i,
  input  logic [POS_W-1:0] player_pos_i,
  input  logic [1:0]       speed_sel_i,
  input  logic             hit_i,
  input  logic             grow_i,
  input  logic             move_ack_i,
  input  logic             moved_i,
  output logic             move_req_o,
  output logic [POS_W-1:0] target_pos_o,
  output logic             body_shift_o,
  output logic [3:0]       body_len_o,
  output logic             fleeing_o,
  output logic             overrun_o
);

  localparam logic [5:0] FLEE_C    = 6'(FLEE_FRAMES);
  localparam logic [3:0] INIT_C    = 4'(INIT_LEN);
  localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

  logic fe_s;
  logic slot_s;

  seq_state_e       state_q, state_d;
  logic             move_req_q, move_req_d;
  logic [POS_W-1:0] target_pos_q, target_pos_d;
  logic             body_shift_q, body_shift_d;
  logic [3:0]       body_len_q, body_len_d;
  logic [5:0]       flee_cnt_q, flee_cnt_d;
  logic             grow_pend_q, grow_pend_d;
  logic             overrun_q, overrun_d;
  logic             fleeing_s;

  frame_tick_gen #(
    .BASE_PERIOD(BASE_PERIOD),
    .SPEED_STEP (SPEED_STEP)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .vsync_i    (vsync_i),
    .speed_sel_i(speed_sel_i),
    .fe_o       (fe_s),
    .slot_o     (slot_s)
  );

  assign fleeing_s = (flee_cnt_q != 6'd0);

  // Next-state logic for flee timer, handshake FSM and body length.
  always_comb begin
    state_d      = state_q;
    move_req_d   = move_req_q;
    target_pos_d = target_pos_q;
    body_len_d   = body_len_q;
    grow_pend_d  = grow_pend_q | grow_i;
    overrun_d    = overrun_q | (slot_s && (state_q != ST_IDLE));

    // A hit reload takes priority over the frame decrement.
    if (hit_i) begin
      flee_cnt_d = FLEE_C;
    end else if (fe_s && fleeing_s) begin
      flee_cnt_d = flee_cnt_q - 6'd1;
    end else begin
      flee_cnt_d = flee_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (slot_s) begin
          target_pos_d = fleeing_s ? FLEE_POS : player_pos_i;
          move_req_d   = 1'b1;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (move_ack_i) begin
          move_req_d = 1'b0;
          state_d    = moved_i ? ST_SHIFT : ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SHIFT: begin
        // A grow arriving now only counts toward the next shift when none
        // was pending; otherwise it coalesces with the one being applied.
        if (grow_pend_q) begin
          grow_pend_d = 1'b0;
          if (body_len_q < MAX_LEN_C) begin
            body_len_d = body_len_q + 4'd1;
          end else begin
            body_len_d = body_len_q;
          end
        end else begin
          grow_pend_d = grow_i;
        end
        state_d = ST_IDLE;
      end
      default: begin
        move_req_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    body_shift_d = (state_d == ST_SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      move_req_q   <= 1'b0;
      target_pos_q <= '0;
      body_shift_q <= 1'b0;
      body_len_q   <= INIT_C;
      flee_cnt_q   <= 6'd0;
      grow_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_req_q   <= move_req_d;
      target_pos_q <= target_pos_d;
      body_shift_q <= body_shift_d;
      body_len_q   <= body_len_d;
      flee_cnt_q   <= flee_cnt_d;
      grow_pend_q  <= grow_pend_d;
      overrun_q    <= overrun_d;
    end
  end

  assign move_req_o   = move_req_q;
  assign target_pos_o = target_pos_q;
  assign body_shift_o = body_shift_q;
  assign body_len_o   = body_len_q;
  assign fleeing_o    = fleeing_s;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_dragon_move_sequencer.sv
module tb_dragon_move_sequencer;

  logic       clk;
  logic       reset;
  logic       vsync_i;
  logic [7:0] player_pos_i;
  logic [1:0] speed_sel_i;
  logic       hit_i;
  logic       grow_i;
  logic       move_ack_i;
  logic       moved_i;
  logic       move_req_o;
  logic [7:0] target_pos_o;
  logic       body_shift_o;
  logic [3:0] body_len_o;
  logic       fleeing_o;
  logic       overrun_o;

  dragon_move_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .vsync_i     (vsync_i),
    .player_pos_i(player_pos_i),
    .speed_sel_i (speed_sel_i),
    .hit_i       (hit_i),
    .grow_i      (grow_i),
    .move_ack_i  (move_ack_i),
    .moved_i     (moved_i),
    .move_req_o  (move_req_o),
    .target_pos_o(target_pos_o),
    .body_shift_o(body_shift_o),
    .body_len_o  (body_len_o),
    .fleeing_o   (fleeing_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] pos;
  } req_exp_t;

  req_exp_t req_q[$];
  int       shift_q[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // head responder controls
  logic ack_hold = 1'b0;
  logic ack_moved = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input int e, input logic [7:0] p);
    req_exp_t x;
    x.edge_n = e;
    x.pos    = p;
    req_q.push_back(x);
  endtask

  // one frame: vsync high 2 cycles, low 6 cycles
  task automatic frame();
    @(negedge clk);
    vsync_i = 1'b1;
    edge_cnt++;
    repeat (2) @(negedge clk);
    vsync_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_grow();
    @(negedge clk);
    grow_i = 1'b1;
    @(negedge clk);
    grow_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vsync_i = ~vsync_i;
      @(negedge clk);
    end
    vsync_i = 1'b0;
    reset = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_req_left"}, req_q.size(), 0);
    check({tag, "_shift_left"}, shift_q.size(), 0);
    req_q.delete();
    shift_q.delete();
  endtask

  // head model: acks a pending request after a short delay unless held off
  initial begin
    move_ack_i = 1'b0;
    moved_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (move_req_o && !ack_hold) begin
        @(negedge clk);
        move_ack_i = 1'b1;
        moved_i    = ack_moved;
        @(negedge clk);
        move_ack_i = 1'b0;
        moved_i    = 1'b0;
      end
    end
  end

  // monitor: compares each new request and each shift against the scoreboard
  initial begin
    logic     req_prev;
    logic     shift_pend;
    int       shift_exp;
    req_exp_t e;
    req_prev   = 1'b0;
    shift_pend = 1'b0;
    shift_exp  = 0;
    forever begin
      @(negedge clk);
      if (shift_pend) begin
        check("body_len_after_shift", int'(body_len_o), shift_exp);
        shift_pend = 1'b0;
      end
      if (move_req_o && !req_prev) begin
        if (req_q.size() == 0) begin
          check("unexpected_move_req", 1, 0);
        end else begin
          e = req_q.pop_front();
          check("req_edge", edge_cnt, e.edge_n);
          check("req_target", int'(target_pos_o), int'(e.pos));
        end
      end
      if (body_shift_o) begin
        if (shift_q.size() == 0) begin
          check("unexpected_body_shift", 1, 0);
        end else begin
          shift_exp  = shift_q.pop_front();
          shift_pend = 1'b1;
        end
      end
      req_prev = move_req_o;
    end
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len_m;
    reset        = 1'b0;
    vsync_i      = 1'b0;
    player_pos_i = 8'h37;
    speed_sel_i  = 2'd0;
    hit_i        = 1'b0;
    grow_i       = 1'b0;

    // reset state
    apply_reset();
    check("rst_move_req", int'(move_req_o), 0);
    check("rst_target", int'(target_pos_o), 0);
    check("rst_body_shift", int'(body_shift_o), 0);
    check("rst_fleeing", int'(fleeing_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_body_len", int'(body_len_o), 2);

    // cadence at speed 0: slots on edges 10 and 20
    ack_hold  = 1'b0;
    ack_moved = 1'b1;
    push_req(10, 8'h37);
    push_req(20, 8'h37);
    shift_q.push_back(2);
    shift_q.push_back(2);
    repeat (25) frame();
    check("cad_overrun", int'(overrun_o), 0);
    check_queues("cadence");

    // flee: period 4, flee lasts 60 edges; slot at edge 60 still flees
    apply_reset();
    speed_sel_i  = 2'd3;
    player_pos_i = 8'h5A;
    @(negedge clk);
    hit_i = 1'b1;
    @(negedge clk);
    hit_i = 1'b0;
    check("flee_start", int'(fleeing_o), 1);
    for (int k = 1; k <= 16; k++) begin
      push_req(4 * k, (4 * k <= 60) ? 8'h00 : 8'h5A);
      shift_q.push_back(2);
    end
    for (int f = 1; f <= 64; f++) begin
      frame();
      if (f == 59) check("flee_edge59", int'(fleeing_o), 1);
      if (f == 60) check("flee_edge60", int'(fleeing_o), 0);
    end
    check_queues("flee");

    // overrun: request held unacked across a dropped slot
    apply_reset();
    speed_sel_i  = 2'd3;
    player_pos_i = 8'h5A;
    ack_hold     = 1'b1;
    push_req(4, 8'h5A);
    repeat (4) frame();
    player_pos_i = 8'h11;
    repeat (5) frame();
    check("ovr_overrun", int'(overrun_o), 1);
    check("ovr_req_held", int'(move_req_o), 1);
    check("ovr_target_frozen", int'(target_pos_o), 8'h5A);
    ack_moved = 1'b0;
    ack_hold  = 1'b0;
    repeat (4) @(negedge clk);
    check("ovr_req_dropped", int'(move_req_o), 0);
    push_req(12, 8'h11);
    repeat (3) frame();
    check("ovr_sticky", int'(overrun_o), 1);
    check_queues("overrun");

    // growth: two grows coalesce, then saturation at 8
    apply_reset();
    speed_sel_i  = 2'd3;
    player_pos_i = 8'h5A;
    ack_moved    = 1'b1;
    pulse_grow();
    pulse_grow();
    len_m = 3;
    push_req(edge_cnt + 4, 8'h5A);
    shift_q.push_back(len_m);
    repeat (4) frame();
    for (int k = 0; k < 8; k++) begin
      pulse_grow();
      len_m = (len_m < 8) ? len_m + 1 : 8;
      push_req(edge_cnt + 4, 8'h5A);
      shift_q.push_back(len_m);
      repeat (4) frame();
    end
    check("grow_saturated", int'(body_len_o), 8);
    check_queues("growth");

    // reset while a request is outstanding
    ack_hold = 1'b1;
    push_req(edge_cnt + 4, 8'h5A);
    repeat (4) frame();
    check("mid_req_active", int'(move_req_o), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_move_req", int'(move_req_o), 0);
    check("mid_rst_body_len", int'(body_len_o), 2);
    check("mid_rst_overrun", int'(overrun_o), 0);
    reset    = 1'b1;
    ack_hold = 1'b0;
    edge_cnt = 0;
    repeat (3) frame();
    check("mid_rst_idle", int'(move_req_o), 0);
    check_queues("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
